// File: rtl/mux_pkg.sv
// Shared constants and helpers for the registered N:1 valid/ready multiplexer.
package mux_pkg;

  localparam logic MUX_MODE_FIXED = 1'b0;
  localparam logic MUX_MODE_RR    = 1'b1;

  // A select bus is always at least one bit, even for degenerate channel counts.
  function automatic int mux_sel_w(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin priority search: first requester at or after ptr wins.
module rr_arbiter import mux_pkg::*; #(
  parameter int NUM_CH = 8,
  parameter int SEL_W  = mux_sel_w(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  output logic [NUM_CH-1:0] grant,
  output logic [SEL_W-1:0]  grant_idx,
  output logic              grant_any
);

  int idx;

  // NOTE: every output gets a default before the search so no path leaves a latch.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    idx       = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = (int'(ptr) + i) % NUM_CH;
      if (!grant_any && req[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = SEL_W'(idx);
        grant_any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_nto1_rr.sv
// Registered N:1 multiplexer with valid/ready on every port; fixed or round-robin select.
// Round-robin support is compiled in only when MUX_RR_EN is defined.
module mux_nto1_rr import mux_pkg::*; #(
  parameter int NUM_CH = 8,
  parameter int DATA_W = 8,
  parameter int SEL_W  = mux_sel_w(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [NUM_CH-1:0]        in_valid,
  output logic [NUM_CH-1:0]        in_ready,
  input  logic                     mode,
  input  logic [SEL_W-1:0]         sel,
  output logic [DATA_W-1:0]        out_data,
  output logic [SEL_W-1:0]         out_ch,
  output logic                     out_valid,
  input  logic                     out_ready
);

  logic [DATA_W-1:0] ch_data [NUM_CH];
  logic [NUM_CH-1:0] fix_grant;
  logic              fix_any;
  logic              sel_ok;
  logic [NUM_CH-1:0] g_onehot;
  logic [SEL_W-1:0]  g_idx;
  logic              g_any;
  logic              load;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_unpack
    assign ch_data[k] = in_data[k*DATA_W +: DATA_W];
  end

  // A select beyond the last channel simply grants nothing.
  assign sel_ok  = 32'(sel) < 32'(NUM_CH);
  assign fix_any = sel_ok && in_valid[sel];

  always_comb begin
    fix_grant = '0;
    if (fix_any) fix_grant[sel] = 1'b1;
  end

`ifdef MUX_RR_EN
  logic [SEL_W-1:0]  ptr;
  logic [NUM_CH-1:0] rr_grant;
  logic [SEL_W-1:0]  rr_idx;
  logic              rr_any;

  rr_arbiter #(.NUM_CH(NUM_CH), .SEL_W(SEL_W)) u_arb (
    .req       (in_valid),
    .ptr       (ptr),
    .grant     (rr_grant),
    .grant_idx (rr_idx),
    .grant_any (rr_any)
  );

  always_comb begin
    if (mode == MUX_MODE_RR) begin
      g_onehot = rr_grant;
      g_idx    = rr_idx;
      g_any    = rr_any;
    end else begin
      g_onehot = fix_grant;
      g_idx    = sel;
      g_any    = fix_any;
    end
  end

  // Pointer follows every accepted grant, so fixed traffic leaves RR resuming fairly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (load) begin
      ptr <= (32'(g_idx) == 32'(NUM_CH - 1)) ? '0 : g_idx + 1'b1;
    end
  end
`else
  logic unused_mode;
  assign unused_mode = mode;

  assign g_onehot = fix_grant;
  assign g_idx    = sel;
  assign g_any    = fix_any;
`endif

  assign load     = (!out_valid || out_ready) && g_any;
  assign in_ready = load ? g_onehot : '0;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= ch_data[g_idx];
      out_ch    <= g_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_nto1_rr.sv
// Directed self-checking bench for mux_nto1_rr; expectations adapt to whether MUX_RR_EN is defined.
module tb_mux_nto1_rr;

  logic clk = 1'b0;
  logic rst_n;

  // 8-channel instance
  logic [63:0] in_data8;
  logic [7:0]  in_valid8, in_ready8;
  logic        mode8;
  logic [2:0]  sel8, out_ch8;
  logic [7:0]  out_data8;
  logic        out_valid8, out_ready8;

  // 12-channel instance, used for out-of-range select
  logic [95:0] in_data12;
  logic [11:0] in_valid12, in_ready12;
  logic [3:0]  sel12, out_ch12;
  logic [7:0]  out_data12;
  logic        out_valid12, out_ready12;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mux_nto1_rr #(.NUM_CH(8), .DATA_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data8), .in_valid(in_valid8),
    .in_ready(in_ready8), .mode(mode8), .sel(sel8), .out_data(out_data8),
    .out_ch(out_ch8), .out_valid(out_valid8), .out_ready(out_ready8)
  );

  mux_nto1_rr #(.NUM_CH(12), .DATA_W(8)) dut12 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data12), .in_valid(in_valid12),
    .in_ready(in_ready12), .mode(1'b0), .sel(sel12), .out_data(out_data12),
    .out_ch(out_ch12), .out_valid(out_valid12), .out_ready(out_ready12)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data8(input int ch, input logic [7:0] v);
    in_data8[ch*8 +: 8] = v;
  endtask

  initial begin
    int exp_ch;
    int rr_seq [4];
    rr_seq = '{6, 2, 6, 2};

    rst_n       = 1'b0;
    in_valid8   = '0;
    mode8       = 1'b0;
    sel8        = '0;
    out_ready8  = 1'b0;
    in_valid12  = '0;
    sel12       = '0;
    out_ready12 = 1'b0;
    for (int k = 0; k < 8; k++)  in_data8[k*8 +: 8]   = 8'hA0 + 8'(k);
    for (int k = 0; k < 12; k++) in_data12[k*8 +: 8]  = 8'hC0 + 8'(k);

    #12;
    check("reset_out_valid", 32'(out_valid8), 32'd0);
    check("reset_out_data",  32'(out_data8),  32'd0);
    check("reset_out_ch",    32'(out_ch8),    32'd0);
    #1 rst_n = 1'b1;
    tick();

    // Fixed select on channel 5, and channel 9 of the 12-channel instance
    mode8 = 1'b0; sel8 = 3'd5; in_valid8 = 8'hFF; out_ready8 = 1'b1;
    sel12 = 4'd9; in_valid12 = 12'hFFF; out_ready12 = 1'b1;
    #1;
    check("fix5_in_ready",  32'(in_ready8),  32'h20);
    check("fix9_in_ready",  32'(in_ready12), 32'h200);
    tick();
    check("fix5_out_valid", 32'(out_valid8), 32'd1);
    check("fix5_out_data",  32'(out_data8),  32'hA5);
    check("fix5_out_ch",    32'(out_ch8),    32'd5);
    check("fix9_out_ch",    32'(out_ch12),   32'd9);
    check("fix9_out_data",  32'(out_data12), 32'hC9);

    // Out-of-range select: no grant, pending word drains
    sel12 = 4'd13;
    sel8  = 3'd7;
    #1;
    check("sel13_in_ready", 32'(in_ready12), 32'd0);
    check("fix7_in_ready",  32'(in_ready8),  32'h80);
    tick();
    check("sel13_out_valid", 32'(out_valid12), 32'd0);
    check("sel13_out_ch_hold", 32'(out_ch12),  32'd9);
    check("fix7_out_ch",     32'(out_ch8),     32'd7);

`ifdef MUX_RR_EN
    // Round-robin over all channels: wrap from 7 leaves ptr at 0
    mode8 = 1'b1;
    for (int i = 0; i < 9; i++) begin
      exp_ch = i % 8;
      #1;
      check("rr_all_in_ready", 32'(in_ready8), 32'(1) << exp_ch);
      tick();
      check("rr_all_out_ch",   32'(out_ch8),   32'(exp_ch));
      check("rr_all_out_data", 32'(out_data8), 32'hA0 + 32'(exp_ch));
      check("rr_all_out_valid", 32'(out_valid8), 32'd1);
    end

    // Fixed grant of channel 2 moves ptr to 3, then only channels 2 and 6 request
    mode8 = 1'b0; sel8 = 3'd2;
    #1;
    check("fix2_in_ready", 32'(in_ready8), 32'h04);
    tick();
    check("fix2_out_ch", 32'(out_ch8), 32'd2);
    mode8 = 1'b1; in_valid8 = 8'h44;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("rr_26_in_ready", 32'(in_ready8), 32'(1) << rr_seq[i]);
      tick();
      check("rr_26_out_ch", 32'(out_ch8), 32'(rr_seq[i]));
    end
`else
    // Mode is ignored: only the selected channel ever wins
    mode8 = 1'b1; sel8 = 3'd2;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("norr_in_ready", 32'(in_ready8), 32'h04);
      tick();
      check("norr_out_ch",   32'(out_ch8),   32'd2);
      check("norr_out_data", 32'(out_data8), 32'hA2);
    end
`endif

    // Backpressure: load channel 3, then stall four cycles while inputs change
    mode8 = 1'b0; sel8 = 3'd3; in_valid8 = 8'hFF; out_ready8 = 1'b1;
    tick();
    check("bp_load_out_ch", 32'(out_ch8), 32'd3);
    out_ready8 = 1'b0; mode8 = 1'b1;
    set_data8(3, 8'h33);
    for (int i = 0; i < 4; i++) begin
      #1;
      check("bp_in_ready", 32'(in_ready8), 32'd0);
      tick();
      check("bp_out_valid", 32'(out_valid8), 32'd1);
      check("bp_out_ch",    32'(out_ch8),    32'd3);
      check("bp_out_data",  32'(out_data8),  32'hA3);
    end
    set_data8(3, 8'hA3);
    out_ready8 = 1'b1;
    for (int i = 0; i < 2; i++) begin
`ifdef MUX_RR_EN
      exp_ch = 4 + i;
`else
      exp_ch = 3;
`endif
      #1;
      check("bp_rel_in_ready", 32'(in_ready8), 32'(1) << exp_ch);
      tick();
      check("bp_rel_out_ch",    32'(out_ch8),    32'(exp_ch));
      check("bp_rel_out_valid", 32'(out_valid8), 32'd1);
    end

    // Asynchronous reset mid-stream with channel 3 registered
    mode8 = 1'b0; sel8 = 3'd3;
    tick();
    check("prerst_out_ch", 32'(out_ch8), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid8), 32'd0);
    check("arst_out_data",  32'(out_data8),  32'd0);
    check("arst_out_ch",    32'(out_ch8),    32'd0);
    #3 rst_n = 1'b1;
    mode8 = 1'b1;
`ifdef MUX_RR_EN
    exp_ch = 0;
`else
    exp_ch = 3;
`endif
    #1;
    check("postrst_in_ready", 32'(in_ready8), 32'(1) << exp_ch);
    tick();
    check("postrst_out_ch",    32'(out_ch8),    32'(exp_ch));
    check("postrst_out_valid", 32'(out_valid8), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mux_nto1_rr.md
# mux_nto1_rr

Parametrised N-channel, W-bit registered multiplexer with valid/ready handshaking on every input and on the output. It is the sequential successor to the gate-level 8:1 selector. It picks one channel per cycle, either by an explicit select (fixed mode) or by a fair round-robin scan (RR mode), and registers the winning word together with its channel index. It sits between per-channel producers and a single shared consumer (bus, FIFO, serialiser).

## Interface
- `NUM_CH`, default 8: number of input channels, ≥ 2.
- `DATA_W`, default 8: data width per channel, ≥ 1.
- `SEL_W`, default `$clog2(NUM_CH)`: derived select width; never overridden.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_data`  in  `NUM_CH*DATA_W`  channel k occupies bits `[k*DATA_W +: DATA_W]`.
- `in_valid`  in  `NUM_CH`  per-channel valid.
- `in_ready`  out  `NUM_CH`  per-channel ready; combinational, at most one bit high.
- `mode`  in  1  0 = fixed select, 1 = round-robin.
- `sel`  in  `SEL_W`  channel index used in fixed mode.
- `out_data`  out  `DATA_W`  registered selected word.
- `out_ch`  out  `SEL_W`  registered index of the channel that supplied `out_data`.
- `out_valid`  out  1  registered output valid.
- `out_ready`  in  1  consumer ready.

## Operation
- Load condition: `load = (!out_valid || out_ready) && grant_any`.
- Fixed mode (`mode=0`):
  - Candidate is channel `sel` only.
  - `grant_any = in_valid[sel]`.
  - If `sel ≥ NUM_CH`, there is no grant and every `in_ready` bit is 0.
- RR mode (`mode=1`):
  - Search starts at `ptr` and wraps modulo `NUM_CH`.
  - The first channel with `in_valid` high is granted.
- Handshake: `in_ready[k] = load && grant[k]`. The input transfer and the output register load happen on the same edge.
- On load: `out_data ← in_data[g]`, `out_ch ← g`, `out_valid ← 1`, and `ptr ← (g+1) mod NUM_CH`. The pointer updates in both modes, so switching to RR after fixed traffic resumes fairly.
- Output transfer without a new load: `out_valid ← 0`. `out_data` and `out_ch` hold their last value.
- Output stall (`out_valid && !out_ready`):
  - All `in_ready` bits are 0.
  - Output registers and `ptr` hold.
  - `out_data` must not change while `out_valid` is high and not accepted.
- `mode` and `sel` are sampled combinationally every cycle. A change takes effect at the next load decision and never alters a word already registered.
- `in_valid` may deassert without a transfer; the block does not require a producer to hold valid.

## Timing
- Reset values (asynchronous assert, synchronous release): `out_valid=0`, `out_data=0`, `out_ch=0`, `ptr=0`.
- Latency: 1 cycle from the input handshake edge to `out_valid`/`out_data`.
- Throughput: one word per cycle when `out_ready` is held high.
- Output path has no combinational path from inputs; all outputs except `in_ready` are registered.
- `in_ready` depends combinationally on `in_valid`, `mode`, `sel`, `out_ready` and state.
- Wrap-around: a grant of channel `NUM_CH-1` sets `ptr=0`.
- Reset mid-transfer drops the registered word with no output handshake.

## Configuration
- `MUX_RR_EN` defined:
  - Round-robin logic and `ptr` are compiled in.
  - `mode` behaves as described above.
- `MUX_RR_EN` undefined:
  - The `mode` port remains but is ignored, and the block is permanently fixed-select.
  - `ptr` and the arbiter are removed.
  - All other timing is identical.

## Structure
- Package `mux_pkg` holds:
  - the mode constants `MUX_MODE_FIXED=1'b0` and `MUX_MODE_RR=1'b1`;
  - the function `mux_sel_w(n)` returning `$clog2(n)` with a minimum of 1.
- Sub-module `rr_arbiter` contains the combinational priority search.
  - Inputs: `req[NUM_CH]`, `ptr`.
  - Outputs: one-hot `grant`, encoded `grant_idx`, `grant_any`.
  - It is instantiated only under `MUX_RR_EN`.
- The top level holds the output register, the pointer and the fixed-select path.

## Test plan
- Fixed mode, `NUM_CH=8`, `sel=5`, all `in_valid=1`, `in_data[5]=8'hA5`, `out_ready=1`: `in_ready=8'b0010_0000`; the next cycle gives `out_valid=1`, `out_data=8'hA5`, `out_ch=5`. With `sel=9` on `NUM_CH=12`, channel 9 is granted; with `sel=13` on `NUM_CH=12`, `in_ready=0` and `out_valid` falls after the pending word drains.
- RR mode, all 8 channels valid continuously, `out_ready=1`: `out_ch` sequence is 0,1,…,7,0 with one word per cycle and no gaps.
- RR with only channels 2 and 6 valid, starting from `ptr=3`: grant order is 6,2,6,2. Channels 0,1,3,4,5,7 never see `in_ready`.
- Backpressure: hold `out_ready=0` for 4 cycles with `out_valid=1`. `out_data`/`out_ch` remain stable, `in_ready=0`, and `ptr` does not change. After release, exactly one transfer occurs per cycle.
- Assert `rst_n=0` asynchronously mid-stream with `out_valid=1`, `out_ch=3`. Outputs clear immediately to `out_valid=0`/`out_data=0`/`out_ch=0`. After release, RR starts at channel 0.
- Build without `MUX_RR_EN`, drive `mode=1`, `sel=2`, all valid: only channel 2 is ever granted.
